regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. It shares the file's single write port (WEN/wsel/wdat) between the in-order pipeline writeback and a multicycle unit (mult/div or a late load) that returns results out of band. It also tracks destination registers reserved by in-flight multicycle ops so the hazard unit can stall dependent reads. It sits between the writeback stage, the multicycle unit, and the `rf` modport of `register_file_if`.

## Interface
- STARVE_LIMIT, 4: consecutive blocked multicycle cycles before a forced grant; legal range 1..15.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- pipe_wen  in  1  pipeline writeback valid.
- pipe_wsel  in  5  pipeline destination register.
- pipe_wdat  in  32  pipeline write data.
- pipe_stall  out  1  pipeline writeback held this cycle; pipeline keeps pipe_* stable and retries.
- mc_valid  in  1  multicycle result valid; held with mc_wsel/mc_wdat stable until mc_ready.
- mc_wsel  in  5  multicycle destination register.
- mc_wdat  in  32  multicycle write data.
- mc_ready  out  1  multicycle result accepted this cycle.
- iss_valid  in  1  multicycle op issued this cycle; reserves iss_wsel.
- iss_wsel  in  5  destination register of the issued op.
- rsel1, rsel2  in  5  decode-stage source registers.
- busy1, busy2  out  1  source register reserved by an in-flight multicycle op.
- rf_WEN  out  1  drives the register file WEN.
- rf_wsel  out  5  drives the register file wsel.
- rf_wdat  out  32  drives the register file wdat.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-high.
- State: FSM {PIPE_PRI, FORCE_MC}; starvation counter `starve` (4 bits); 32-bit `pending` scoreboard.
- Conflict: `pipe_req = pipe_wen && pipe_wsel != 0`.
- PIPE_PRI:
  - pipe_stall = 0.
  - mc_ready = mc_valid && !pipe_req.
  - If pipe_req: rf_* = pipe_*.
  - Else if mc_valid: rf_* = mc_*, with rf_WEN = (mc_wsel != 0).
  - Else rf_WEN = 0.
- FORCE_MC:
  - pipe_stall = pipe_wen.
  - mc_ready = mc_valid.
  - rf_* = mc_*, with rf_WEN = mc_valid && mc_wsel != 0.
  - Always returns to PIPE_PRI after one cycle.
- Starvation counter:
  - In PIPE_PRI, a blocked cycle (mc_valid && !mc_ready) sets starve <= starve+1. If starve+1 == STARVE_LIMIT, next state is FORCE_MC and starve <= 0.
  - On an mc handshake, or when mc_valid = 0, starve <= 0.
  - In FORCE_MC, starve <= 0.
- Writes to r0:
  - Never drive rf_WEN.
  - A pipeline write to r0 is not a conflict, so mc is granted that cycle.
  - An mc result to r0 still handshakes.
- Scoreboard:
  - Set: iss_valid && iss_wsel != 0 sets pending[iss_wsel].
  - Clear: an mc handshake (mc_valid && mc_ready) clears pending[mc_wsel].
  - Same register set and cleared in the same cycle: set wins.
  - pending[0] is always 0.
- busy outputs: busy1 = pending[rsel1], busy2 = pending[rsel2]. They are combinational from registered state. There is no same-cycle forwarding of the clearing write; the register file's write-then-read timing handles that.
- Multiple outstanding issues to the same register: the first mc return clears the bit. The issuing logic must not issue a second op to a pending register (use busy on the destination).

## Timing
- Reset values: state PIPE_PRI, starve 0, pending 0.
- While RST is high, outputs are forced: pipe_stall 0, mc_ready 0, rf_WEN 0, busy1/busy2 0.
- rf_* and mc_ready/pipe_stall are combinational (zero latency) from inputs and state. The write lands at the register file's write edge in the same cycle.
- The scoreboard updates on the edge after issue or handshake. busy is visible the cycle after iss_valid and drops the cycle after the mc handshake.
- Worst-case mc wait: STARVE_LIMIT blocked cycles plus one forced cycle.
- mc_valid deasserted during FORCE_MC is a protocol violation. The FSM still spends exactly one cycle in FORCE_MC with rf_WEN = 0 and pipe_stall = pipe_wen.
- RST asserted mid-FORCE_MC, or with pending bits set: immediate return to reset values and all reservations are discarded.

## Test plan
- Reset, then idle:
  - With RST high and all inputs toggling: rf_WEN = 0, mc_ready = 0, pipe_stall = 0, busy = 0.
  - After release with no requests: rf_WEN = 0.
- No contention:
  - pipe_wen = 1, wsel = 5, wdat = 0xDEADBEEF → rf_WEN = 1, rf_wsel = 5, rf_wdat = 0xDEADBEEF, pipe_stall = 0.
  - Next cycle, mc_valid only, wsel = 7 → mc_ready = 1, rf_wsel = 7.
- Starvation, STARVE_LIMIT = 4:
  - mc_valid (wsel = 9, data 0x1234) and pipe_req held continuously.
  - mc_ready = 0 for cycles 0–3.
  - Cycle 4: pipe_stall = 1, mc_ready = 1, rf_wsel = 9, rf_wdat = 0x1234.
  - Cycle 5: pipeline write completes.
- r0 handling:
  - pipe write to r0 with mc_valid to r3 → mc_ready = 1, rf_wsel = 3.
  - mc to r0 → mc_ready = 1, rf_WEN = 0.
- Scoreboard:
  - iss_valid, iss_wsel = 12; rsel1 = 12 → busy1 = 1 from the next cycle.
  - mc handshake to r12 → busy1 = 0 the cycle after.
  - Same-cycle issue and return to r12 → busy1 stays 1.
- Async reset mid-operation:
  - pending = {r4, r8} and FSM in FORCE_MC; assert RST between edges.
  - Outputs go to reset values immediately.
  - After release: busy = 0 for r4/r8, and the FSM is in PIPE_PRI.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with multicycle destination scoreboard
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_wsel,
    input  logic [31:0] pipe_wdat,
    output logic        pipe_stall,
    input  logic        mc_valid,
    input  logic [4:0]  mc_wsel,
    input  logic [31:0] mc_wdat,
    output logic        mc_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wsel,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic        busy1,
    output logic        busy2,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat
);

    typedef enum logic {
        PIPE_PRI = 1'b0,
        FORCE_MC = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    logic [3:0]  starve;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        pipe_req;
    logic        mc_hs;

    // A pipeline write to r0 is discarded by the file, so it never blocks the multicycle unit
    assign pipe_req = pipe_wen && (pipe_wsel != 5'd0);
    assign mc_hs    = mc_valid && mc_ready;

    // Write-port mux and handshakes; everything is held quiet while reset is asserted
    always_comb begin
        pipe_stall = 1'b0;
        mc_ready   = 1'b0;
        rf_WEN     = 1'b0;
        rf_wsel    = pipe_wsel;
        rf_wdat    = pipe_wdat;
        if (!RST) begin
            case (state)
                PIPE_PRI: begin
                    mc_ready = mc_valid && !pipe_req;
                    if (pipe_req) begin
                        rf_WEN = 1'b1;
                    end else if (mc_valid) begin
                        rf_WEN  = (mc_wsel != 5'd0);
                        rf_wsel = mc_wsel;
                        rf_wdat = mc_wdat;
                    end
                end
                FORCE_MC: begin
                    pipe_stall = pipe_wen;
                    mc_ready   = mc_valid;
                    rf_WEN     = mc_valid && (mc_wsel != 5'd0);
                    rf_wsel    = mc_wsel;
                    rf_wdat    = mc_wdat;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard next value: a new reservation overrides a same-cycle release, r0 never reserved
    always_comb begin
        pending_next = pending;
        if (mc_hs) begin
            pending_next[mc_wsel] = 1'b0;
        end
        if (iss_valid) begin
            pending_next[iss_wsel] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Arbitration FSM with starvation counter, plus scoreboard register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= PIPE_PRI;
            starve  <= 4'd0;
            pending <= 32'd0;
        end else begin
            pending <= pending_next;
            case (state)
                PIPE_PRI: begin
                    if (mc_valid && !mc_ready) begin
                        if (starve + 4'd1 == LIMIT) begin
                            state  <= FORCE_MC;
                            starve <= 4'd0;
                        end else begin
                            starve <= starve + 4'd1;
                        end
                    end else begin
                        starve <= 4'd0;
                    end
                end
                FORCE_MC: begin
                    state  <= PIPE_PRI;
                    starve <= 4'd0;
                end
                default: begin
                    state  <= PIPE_PRI;
                    starve <= 4'd0;
                end
            endcase
        end
    end

    // Reservation lookups for the decode-stage sources
    assign busy1 = !RST && pending[rsel1];
    assign busy2 = !RST && pending[rsel2];

endmodule
